// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory.
// Optional DMEM_STATS_EN build adds request statistics counters.
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int be_w_f(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w_f(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_w_f(input int depth);
        return $clog2(depth);
    endfunction

    // Misaligned: offset bits set. Out of range: bits above index set.
    function automatic logic addr_err(
        input logic [63:0] addr,
        input int          off_w,
        input int          idx_w
    );
        logic [63:0] lo_mask;
        logic        mis;
        logic        oor;
        lo_mask = (64'd1 << off_w) - 64'd1;
        mis     = |(addr & lo_mask);
        oor     = |(addr >> (off_w + idx_w));
        return mis | oor;
    endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-latency response pipeline for the data memory.
// Reset flushes every in-flight response.
module dmem_rsp_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic [LAT-1:0]    v_q;
    logic [LAT-1:0]    e_q;
    logic [DATA_W-1:0] d_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            e_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= in_valid;
            e_q[0] <= in_valid && in_err;
            d_q[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                e_q[i] <= e_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign out_valid = v_q[LAT-1];
    assign out_err   = e_q[LAT-1];
    assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/dmem_pipelined.sv
// Word RAM with valid/ready requests, fixed-latency responses, post-reset clear.
// Define DMEM_STATS_EN to add stat_rd / stat_wr / stat_err counters.
module dmem_pipelined
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]         stat_rd,
    output logic [31:0]         stat_wr,
    output logic [31:0]         stat_err
`endif
);

    localparam int BE_W  = be_w_f(DATA_W);
    localparam int OFF_W = off_w_f(DATA_W);
    localparam int IDX_W = idx_w_f(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_t            state_q;
    state_t            state_n;
    logic [IDX_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              err;
    logic              good_rd;
    logic              good_wr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    assign accept  = req_valid && req_ready;
    assign idx     = req_addr[OFF_W +: IDX_W];
    assign err     = addr_err(64'(req_addr), OFF_W, IDX_W);
    assign good_rd = accept && !req_we && !err;
    assign good_wr = accept && req_we && !err && (|req_be);
    assign rd_word = good_rd ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            INIT:    if (cnt_q == LAST) state_n = RUN;
            RUN:     state_n = RUN;
            default: state_n = INIT;
        endcase
    end

    // No acceptance while rst is high, so a reset cycle never writes.
    always_comb begin
        req_ready = (state_q == RUN) && !rst;
        init_done = (state_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (good_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    dmem_rsp_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_rsp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept && (err || !req_we)),
        .in_err    (accept && err),
        .in_data   (rd_word),
        .out_valid (rsp_valid),
        .out_err   (rsp_err),
        .out_data  (rsp_rdata)
    );

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else begin
            if (good_rd)       stat_rd  <= stat_rd + 32'd1;
            if (good_wr)       stat_wr  <= stat_wr + 32'd1;
            if (accept && err) stat_err <= stat_err + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_pipelined.sv
// Directed bench: one READ_LAT=1 and one READ_LAT=3 instance on shared stimulus.
// Latency-1 instance carries most checks; latency-3 covers pipelining and flush.
module tb_dmem_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;

    logic        ready1, v1, e1, done1;
    logic [15:0] d1;
    logic        ready3, v3, e3, done3;
    logic [15:0] d3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_pipelined #(
        .DATA_W(16), .DEPTH(256), .ADDR_W(16), .READ_LAT(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1),
        .init_done(done1)
    );

    dmem_pipelined #(
        .DATA_W(16), .DEPTH(256), .ADDR_W(16), .READ_LAT(3)
    ) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(v3), .rsp_rdata(d3), .rsp_err(e3),
        .init_done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_v;
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);

        chk("rst_ready", ready1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_rdata", d1, 0);
        chk("rst_err", e1, 0);
        chk("rst_done", done1, 0);
        chk("rst_valid3", v3, 0);

        // INIT lasts exactly 256 cycles after reset release
        rst = 1'b0;
        repeat (255) @(negedge clk);
        chk("init_ready_255", ready1, 0);
        chk("init_done_255", done1, 0);
        chk("init_ready3_255", ready3, 0);
        @(negedge clk);
        chk("init_ready_256", ready1, 1);
        chk("init_done_256", done1, 1);
        chk("init_done3_256", done3, 1);

        send(1'b0, 16'h00FE, 16'h0, 2'b00);
        @(negedge clk);
        idle();
        chk("rd_fe_valid", v1, 1);
        chk("rd_fe_data", d1, 16'h0000);
        chk("rd_fe_err", e1, 0);
        chk("rd_fe_v3_early", v3, 0);
        @(negedge clk);
        chk("rd_fe_pulse", v1, 0);
        chk("rd_fe_v3_early2", v3, 0);
        @(negedge clk);
        chk("rd_fe_v3", v3, 1);
        chk("rd_fe_d3", d3, 16'h0000);

        send(1'b1, 16'h0010, 16'hBEEF, 2'b11);
        @(negedge clk);
        chk("wr_no_rsp", v1, 0);
        send(1'b0, 16'h0010, 16'h0, 2'b00);
        @(negedge clk);
        idle();
        chk("rd_beef_valid", v1, 1);
        chk("rd_beef_data", d1, 16'hBEEF);
        chk("rd_beef_err", e1, 0);

        send(1'b1, 16'h0010, 16'h1234, 2'b01);
        @(negedge clk);
        send(1'b0, 16'h0010, 16'h0, 2'b00);
        @(negedge clk);
        idle();
        chk("rd_be01_data", d1, 16'hBE34);

        send(1'b1, 16'h0010, 16'hFFFF, 2'b00);
        @(negedge clk);
        chk("wr_be0_no_rsp", v1, 0);
        send(1'b0, 16'h0010, 16'h0, 2'b00);
        @(negedge clk);
        idle();
        chk("rd_be0_data", d1, 16'hBE34);

        send(1'b0, 16'h0011, 16'h0, 2'b00);
        @(negedge clk);
        chk("mis_valid", v1, 1);
        chk("mis_err", e1, 1);
        chk("mis_data", d1, 0);
        send(1'b1, 16'h0200, 16'hFFFF, 2'b11);
        @(negedge clk);
        chk("oor_valid", v1, 1);
        chk("oor_err", e1, 1);
        chk("oor_data", d1, 0);
        send(1'b0, 16'h0000, 16'h0, 2'b00);
        @(negedge clk);
        idle();
        chk("rd_w0_valid", v1, 1);
        chk("rd_w0_err", e1, 0);
        chk("rd_w0_data", d1, 0);
        @(negedge clk);
        chk("idle_valid", v1, 0);
        chk("idle_data", d1, 0);
        chk("idle_err", e1, 0);

        for (int i = 0; i < 8; i++) begin
            send(1'b1, 16'(16'h0020 + 2 * i), 16'(16'hA000 + i), 2'b11);
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);

        // Back-to-back reads: check both latencies every cycle
        for (int j = 0; j < 12; j++) begin
            if (j >= 1) begin
                exp_v = (j <= 8);
                chk($sformatf("b2b1_v_%0d", j), v1, 32'(exp_v));
                chk($sformatf("b2b1_d_%0d", j), d1,
                    exp_v ? 32'hA000 + j - 1 : 32'h0);
                exp_v = (j >= 3) && (j <= 10);
                chk($sformatf("b2b3_v_%0d", j), v3, 32'(exp_v));
                chk($sformatf("b2b3_d_%0d", j), d3,
                    exp_v ? 32'hA000 + j - 3 : 32'h0);
            end
            if (j < 8) send(1'b0, 16'(16'h0020 + 2 * j), 16'h0, 2'b00);
            else idle();
            @(negedge clk);
        end

        send(1'b1, 16'h0010, 16'hBEEF, 2'b11);
        @(negedge clk);
        send(1'b0, 16'h0010, 16'h0, 2'b00);
        @(negedge clk);
        send(1'b0, 16'h0010, 16'h0, 2'b00);
        @(negedge clk);
        idle();
        rst = 1'b1;
        chk("flush_v3_pre", v3, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("flush_v3_rst_%0d", k), v3, 0);
            chk($sformatf("flush_v1_rst_%0d", k), v1, 0);
            chk($sformatf("flush_ready_rst_%0d", k), ready1, 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("flush_v3_init_%0d", k), v3, 0);
            chk($sformatf("ready3_init_%0d", k), ready3, 0);
        end
        repeat (250) @(negedge clk);
        chk("reinit_ready_255", ready1, 0);
        @(negedge clk);
        chk("reinit_ready_256", ready1, 1);
        chk("reinit_done3", done3, 1);

        send(1'b0, 16'h0010, 16'h0, 2'b00);
        @(negedge clk);
        idle();
        chk("clr_v1", v1, 1);
        chk("clr_d1", d1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("clr_v3", v3, 1);
        chk("clr_d3", d3, 0);
        chk("clr_e3", e3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_pipelined.md
Name: dmem_pipelined

Overview:
- Parametrised successor to the single-port 16-bit data memory.
- Word-organised RAM behind a valid/ready request port and a fixed-latency response port.
- Supports byte-enable writes, configurable width, depth and read latency, alignment and range checking, and a post-reset clearing sequence.
- Sits between the CPU load/store stage and the data bus.

Parameters:
- DATA_W, 16, word width in bits; multiple of 8, 8..64.
- DEPTH, 256, number of words; power of 2, ≥2.
- ADDR_W, 16, byte-address width; must satisfy ADDR_W ≥ log2(DEPTH)+log2(DATA_W/8).
- READ_LAT, 1, read response latency in cycles after request acceptance; 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- rsp_valid  out  1  read response or error response valid; single-cycle pulse.
- rsp_rdata  out  DATA_W  read data; 0 when rsp_err=1.
- rsp_err  out  1  misaligned or out-of-range request.
- init_done  out  1  clearing sequence finished.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0. The response pipeline is flushed.
- FSM states: INIT, RUN.
  - rst forces INIT with the clear counter at 0.
  - INIT writes 0 to word[cnt] each cycle, cnt 0..DEPTH-1. After writing DEPTH-1, go to RUN; init_done=1 from the next cycle. INIT lasts exactly DEPTH cycles.
  - In RUN, req_ready=1 every cycle; the block has no backpressure.
- Handshake: a request is accepted when req_valid && req_ready. Requests offered while req_ready=0 are ignored; the requester holds them.
- Address decode:
  - Word index = req_addr[log2(DATA_W/8) +: log2(DEPTH)].
  - Misaligned: low log2(DATA_W/8) bits are nonzero.
  - Out of range: any address bit above the index field is set.
- Write (accepted, no error): updates the enabled bytes at the clock edge; disabled bytes are unchanged. No response is issued. If be=0 the write is a no-op with no response.
- Read (accepted, no error): rsp_valid=1 exactly READ_LAT cycles after acceptance, with rsp_rdata = word contents, rsp_err=0.
- Erroneous request (read or write): no memory update. After READ_LAT cycles: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Throughput: one request per cycle; responses come back in order.
- Ordering: a read accepted at cycle N+1 after a write to the same word at cycle N returns the new data. The memory array is read-first within a cycle, and no same-cycle read/write conflict is possible.
- rsp_rdata holds 0 when rsp_valid=0.
- rst mid-operation: in-flight responses are discarded (never emitted) and INIT restarts. Contents are cleared again.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: adds outputs stat_rd, stat_wr, stat_err, each 32 bits.
  - Counts accepted good reads, accepted good writes with be≠0, and error requests.
  - All counters reset to 0 on rst and wrap at 2^32.
  - Not incremented during INIT.
- Undefined: the counter outputs and logic are absent; all other behaviour is identical.

Decomposition:
- Package dmem_pkg: derived constants (BE_W, OFF_W, IDX_W), FSM state encoding, and the error-classification function.
- Natural sub-module dmem_rsp_pipe: a READ_LAT-deep valid/data/err shift pipeline with flush-on-reset. The top level keeps the FSM, decode and RAM.

Test Plan:
- Reset then idle: req_ready=0 for 256 cycles, then init_done=1. A read of addr 0x00FE returns 0x0000 one cycle after acceptance.
- Write 0xBEEF at 0x0010 with be=2'b11, then read at 0x0010 on the next cycle: rsp_rdata=0xBEEF, rsp_err=0 at READ_LAT.
- Byte enables: write 0x1234 with be=2'b01 over 0xBEEF, then read: 0xBE34.
- Errors: read at 0x0011 gives rsp_err=1, rdata=0. Write at 0x0200 (DEPTH=256) gives rsp_err=1, and a read of word 0 is unchanged.
- Back-to-back reads at READ_LAT=3, 8 consecutive addresses: 8 in-order rsp_valid pulses starting 3 cycles after the first acceptance.
- Assert rst with 2 reads in flight: no rsp_valid is emitted, INIT reruns, and previously written 0xBEEF reads back as 0.
